mcpu_mem_arb_wrr: RTL and testbench

MCPU_MEM_ARB_WRR -- requirements
Module: mcpu_mem_arb_wrr

---
 rtl/mcpu_mem_arb_wrr_pkg.sv | 27 ++
 rtl/mcpu_mem_arb_wrr_fifo.sv | 52 +++++
 rtl/mcpu_mem_arb_wrr.sv | 226 ++++++++++++++++++++++
 tb/tb_mcpu_mem_arb_wrr.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_mem_arb_wrr_pkg.sv
// rtl/mcpu_mem_arb_wrr_pkg.sv - shared MCPU_MEM constants: LTC opcodes, field widths, CSR payload layout
package mcpu_mem_arb_wrr_pkg;

    localparam int LTC_OPCODE_BITS = 3;
    localparam int LTC_ADDR_BITS   = 27;
    localparam int LTC_DATA_BITS   = 256;
    localparam int LTC_WBE_BITS    = 32;

    localparam logic [LTC_OPCODE_BITS-1:0] LTC_OP_NOP          = 3'd0;
    localparam logic [LTC_OPCODE_BITS-1:0] LTC_OP_READ         = 3'd1;
    localparam logic [LTC_OPCODE_BITS-1:0] LTC_OP_WRITE        = 3'd2;
    localparam logic [LTC_OPCODE_BITS-1:0] LTC_OP_READTHROUGH  = 3'd3;
    localparam logic [LTC_OPCODE_BITS-1:0] LTC_OP_WRITETHROUGH = 3'd4;
    localparam logic [LTC_OPCODE_BITS-1:0] LTC_OP_FLUSH        = 3'd5;

    // CSR payload is {prio_mode, credits}: credits start at bit 0, prio_mode sits just above them.
    localparam int CSR_CREDITS_LSB = 0;

    function automatic int csr_prio_pos(input int credits_bits);
        return CSR_CREDITS_LSB + credits_bits;
    endfunction

    function automatic logic ltc_is_read(input logic [LTC_OPCODE_BITS-1:0] op);
        return (op == LTC_OP_READ) || (op == LTC_OP_READTHROUGH);
    endfunction

endpackage

// File: rtl/mcpu_mem_arb_wrr_fifo.sv
// rtl/mcpu_mem_arb_wrr_fifo.sv - small synchronous FIFO with async active-high reset (read-tag queue)
module mcpu_mem_arb_wrr_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_BITS = $clog2(DEPTH);

    logic [PTR_BITS:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              do_push;
    logic              do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[PTR_BITS] != rd_ptr_q[PTR_BITS]) &&
                   (wr_ptr_q[PTR_BITS-1:0] == rd_ptr_q[PTR_BITS-1:0]);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        pop_data = mem_q[rd_ptr_q[PTR_BITS-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_BITS-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/mcpu_mem_arb_wrr.sv
// rtl/mcpu_mem_arb_wrr.sv - weighted round-robin / fixed-priority arbiter from CLIENTS ports onto one LTC port
module mcpu_mem_arb_wrr
    import mcpu_mem_arb_wrr_pkg::*;
#(
    parameter int CLIENTS         = 4,
    parameter int CLIENTS_BITS    = 2,
    parameter int CREDITS_BITS    = 3,
    parameter int CREDITS_DEFAULT = 1,
    parameter int RDQ_DEPTH       = 8
) (
    input  logic                          clkrst_mem_clk,
    input  logic                          clkrst_mem_rst,

    input  logic                          arb2ltc_stall,
    output logic                          arb2ltc_valid,
    output logic [2:0]                    arb2ltc_opcode,
    output logic [31:5]                   arb2ltc_addr,
    output logic [255:0]                  arb2ltc_wdata,
    output logic [31:0]                   arb2ltc_wbe,
    input  logic [255:0]                  arb2ltc_rdata,
    input  logic                          arb2ltc_rvalid,

    input  logic [CLIENTS-1:0]            cli2arb_valid,
    input  logic [CLIENTS*3-1:0]          cli2arb_opcode,
    input  logic [CLIENTS*27-1:0]         cli2arb_addr,
    input  logic [CLIENTS*256-1:0]        cli2arb_wdata,
    input  logic [CLIENTS*32-1:0]         cli2arb_wbe,
    output logic [CLIENTS-1:0]            cli2arb_stall,
    output logic [255:0]                  cli2arb_rdata,
    output logic [CLIENTS-1:0]            cli2arb_rvalid,

    input  logic                          csr_wr,
    input  logic [CLIENTS_BITS-1:0]       csr_idx,
    input  logic [CREDITS_BITS:0]         csr_wdata,
    output logic [CREDITS_BITS:0]         csr_rdata
);

    localparam int PRIO_POS = csr_prio_pos(CREDITS_BITS);

    logic [2:0]   cli_opcode [CLIENTS];
    logic [26:0]  cli_addr   [CLIENTS];
    logic [255:0] cli_wdata  [CLIENTS];
    logic [31:0]  cli_wbe    [CLIENTS];

    logic [CLIENTS_BITS-1:0] cur_client_num_q, cur_client_num_d;
    logic [CREDITS_BITS-1:0] credits_left_q, credits_left_d;
    logic [CREDITS_BITS-1:0] cli_credits_q [CLIENTS];
    logic [CREDITS_BITS-1:0] cli_credits_d [CLIENTS];
    logic                    prio_mode_q, prio_mode_d;

    logic         arb2ltc_valid_q, arb2ltc_valid_d;
    logic [2:0]   arb2ltc_opcode_q, arb2ltc_opcode_d;
    logic [26:0]  arb2ltc_addr_q, arb2ltc_addr_d;
    logic [255:0] arb2ltc_wdata_q, arb2ltc_wdata_d;
    logic [31:0]  arb2ltc_wbe_q, arb2ltc_wbe_d;

    logic                    rvalid_q, rvalid_d;
    logic [255:0]            rdata_q, rdata_d;
    logic [CLIENTS_BITS-1:0] rtag_q, rtag_d;

    logic                    sel_valid;
    logic                    is_read;
    logic                    rdq_wait;
    logic                    rdq_push;
    logic                    rdq_full;
    logic                    rdq_empty;
    logic [CLIENTS_BITS-1:0] rdq_head;
    logic [CLIENTS_BITS-1:0] next_rr;
    logic                    next_rr_found;
    logic [CLIENTS_BITS-1:0] lowest;
    logic                    lowest_found;

    always_comb begin
        for (int c = 0; c < CLIENTS; c++) begin
            cli_opcode[c] = cli2arb_opcode[c*3 +: 3];
            cli_addr[c]   = cli2arb_addr[c*27 +: 27];
            cli_wdata[c]  = cli2arb_wdata[c*256 +: 256];
            cli_wbe[c]    = cli2arb_wbe[c*32 +: 32];
        end
    end

    always_comb begin
        sel_valid = cli2arb_valid[cur_client_num_q];
        is_read   = ltc_is_read(cli_opcode[cur_client_num_q]);
        // Full flag is sampled before any same-cycle pop, so a full queue always blocks the push.
        rdq_wait  = sel_valid && is_read && rdq_full;
        rdq_push  = sel_valid && is_read && !rdq_full && !arb2ltc_stall;

        next_rr       = cur_client_num_q;
        next_rr_found = 1'b0;
        for (int i = 1; i < CLIENTS; i++) begin
            if (!next_rr_found && cli2arb_valid[(int'(cur_client_num_q) + i) % CLIENTS]) begin
                next_rr       = CLIENTS_BITS'((int'(cur_client_num_q) + i) % CLIENTS);
                next_rr_found = 1'b1;
            end
        end

        lowest       = cur_client_num_q;
        lowest_found = 1'b0;
        for (int i = 0; i < CLIENTS; i++) begin
            if (!lowest_found && cli2arb_valid[i]) begin
                lowest       = CLIENTS_BITS'(i);
                lowest_found = 1'b1;
            end
        end
    end

    always_comb begin
        cur_client_num_d = cur_client_num_q;
        credits_left_d   = credits_left_q;
        if (!arb2ltc_stall) begin
            if (prio_mode_q) begin
                cur_client_num_d = lowest;
            end else if (credits_left_q == '0 || !sel_valid) begin
                // Credits load at grant time, so a CSR write to the active client lands on its next turn.
                cur_client_num_d = next_rr;
                credits_left_d   = cli_credits_q[next_rr];
            end else begin
                credits_left_d = credits_left_q - 1'b1;
            end
        end
    end

    always_comb begin
        cli_credits_d = cli_credits_q;
        prio_mode_d   = prio_mode_q;
        if (csr_wr) begin
            if (int'(csr_idx) < CLIENTS) begin
                cli_credits_d[csr_idx] = csr_wdata[CSR_CREDITS_LSB +: CREDITS_BITS];
            end
            prio_mode_d = csr_wdata[PRIO_POS];
        end
        csr_rdata = {prio_mode_q,
                     (int'(csr_idx) < CLIENTS) ? cli_credits_q[csr_idx] : {CREDITS_BITS{1'b0}}};
    end

    always_comb begin
        arb2ltc_valid_d  = arb2ltc_valid_q;
        arb2ltc_opcode_d = arb2ltc_opcode_q;
        arb2ltc_addr_d   = arb2ltc_addr_q;
        arb2ltc_wdata_d  = arb2ltc_wdata_q;
        arb2ltc_wbe_d    = arb2ltc_wbe_q;
        if (!arb2ltc_stall) begin
            arb2ltc_valid_d  = sel_valid && !rdq_wait;
            arb2ltc_opcode_d = cli_opcode[cur_client_num_q];
            arb2ltc_addr_d   = cli_addr[cur_client_num_q];
            arb2ltc_wdata_d  = cli_wdata[cur_client_num_q];
            arb2ltc_wbe_d    = cli_wbe[cur_client_num_q];
        end

        for (int c = 0; c < CLIENTS; c++) begin
            cli2arb_stall[c] = cli2arb_valid[c] &&
                               ((CLIENTS_BITS'(c) != cur_client_num_q) || arb2ltc_stall || rdq_wait);
        end
    end

    always_comb begin
        rvalid_d = arb2ltc_rvalid;
        rdata_d  = arb2ltc_rvalid ? arb2ltc_rdata : rdata_q;
        rtag_d   = arb2ltc_rvalid ? rdq_head : rtag_q;
        for (int c = 0; c < CLIENTS; c++) begin
            cli2arb_rvalid[c] = rvalid_q && (rtag_q == CLIENTS_BITS'(c));
        end
    end

    always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
        if (clkrst_mem_rst) begin
            cur_client_num_q <= '0;
            credits_left_q   <= CREDITS_BITS'(CREDITS_DEFAULT);
            for (int c = 0; c < CLIENTS; c++) begin
                cli_credits_q[c] <= CREDITS_BITS'(CREDITS_DEFAULT);
            end
            prio_mode_q      <= 1'b0;
            arb2ltc_valid_q  <= 1'b0;
            arb2ltc_opcode_q <= '0;
            arb2ltc_addr_q   <= '0;
            arb2ltc_wdata_q  <= '0;
            arb2ltc_wbe_q    <= '0;
            rvalid_q         <= 1'b0;
            rdata_q          <= '0;
            rtag_q           <= '0;
        end else begin
            cur_client_num_q <= cur_client_num_d;
            credits_left_q   <= credits_left_d;
            cli_credits_q    <= cli_credits_d;
            prio_mode_q      <= prio_mode_d;
            arb2ltc_valid_q  <= arb2ltc_valid_d;
            arb2ltc_opcode_q <= arb2ltc_opcode_d;
            arb2ltc_addr_q   <= arb2ltc_addr_d;
            arb2ltc_wdata_q  <= arb2ltc_wdata_d;
            arb2ltc_wbe_q    <= arb2ltc_wbe_d;
            rvalid_q         <= rvalid_d;
            rdata_q          <= rdata_d;
            rtag_q           <= rtag_d;
        end
    end

    assign arb2ltc_valid  = arb2ltc_valid_q;
    assign arb2ltc_opcode = arb2ltc_opcode_q;
    assign arb2ltc_addr   = arb2ltc_addr_q;
    assign arb2ltc_wdata  = arb2ltc_wdata_q;
    assign arb2ltc_wbe    = arb2ltc_wbe_q;
    assign cli2arb_rdata  = rdata_q;

    mcpu_mem_arb_wrr_fifo #(
        .DEPTH (RDQ_DEPTH),
        .WIDTH (CLIENTS_BITS)
    ) u_rdq (
        .clk       (clkrst_mem_clk),
        .rst       (clkrst_mem_rst),
        .push      (rdq_push),
        .push_data (cur_client_num_q),
        .pop       (arb2ltc_rvalid),
        .pop_data  (rdq_head),
        .full      (rdq_full),
        .empty     (rdq_empty)
    );

    // A return with nothing outstanding means the LTC and arbiter disagree on in-flight reads.
    always @(posedge clkrst_mem_clk) begin
        if (!clkrst_mem_rst) begin
            assert (!(arb2ltc_rvalid && rdq_empty));
        end
    end

endmodule

// File: tb/tb_mcpu_mem_arb_wrr.sv
// tb/tb_mcpu_mem_arb_wrr.sv - directed self-checking bench for mcpu_mem_arb_wrr
module tb_mcpu_mem_arb_wrr;
    import mcpu_mem_arb_wrr_pkg::*;

    localparam int CLIENTS = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   arb2ltc_stall = 1'b0;
    logic                   arb2ltc_valid;
    logic [2:0]             arb2ltc_opcode;
    logic [31:5]            arb2ltc_addr;
    logic [255:0]           arb2ltc_wdata;
    logic [31:0]            arb2ltc_wbe;
    logic [255:0]           arb2ltc_rdata = '0;
    logic                   arb2ltc_rvalid = 1'b0;
    logic [CLIENTS-1:0]     cli2arb_valid = '0;
    logic [CLIENTS*3-1:0]   cli2arb_opcode = '0;
    logic [CLIENTS*27-1:0]  cli2arb_addr = '0;
    logic [CLIENTS*256-1:0] cli2arb_wdata = '0;
    logic [CLIENTS*32-1:0]  cli2arb_wbe = '0;
    logic [CLIENTS-1:0]     cli2arb_stall;
    logic [255:0]           cli2arb_rdata;
    logic [CLIENTS-1:0]     cli2arb_rvalid;
    logic                   csr_wr = 1'b0;
    logic [1:0]             csr_idx = '0;
    logic [3:0]             csr_wdata = '0;
    logic [3:0]             csr_rdata;

    int checks = 0;
    int failures = 0;

    mcpu_mem_arb_wrr #(
        .CLIENTS(4), .CLIENTS_BITS(2), .CREDITS_BITS(3), .CREDITS_DEFAULT(1), .RDQ_DEPTH(8)
    ) dut (
        .clkrst_mem_clk (clk),
        .clkrst_mem_rst (rst),
        .arb2ltc_stall  (arb2ltc_stall),
        .arb2ltc_valid  (arb2ltc_valid),
        .arb2ltc_opcode (arb2ltc_opcode),
        .arb2ltc_addr   (arb2ltc_addr),
        .arb2ltc_wdata  (arb2ltc_wdata),
        .arb2ltc_wbe    (arb2ltc_wbe),
        .arb2ltc_rdata  (arb2ltc_rdata),
        .arb2ltc_rvalid (arb2ltc_rvalid),
        .cli2arb_valid  (cli2arb_valid),
        .cli2arb_opcode (cli2arb_opcode),
        .cli2arb_addr   (cli2arb_addr),
        .cli2arb_wdata  (cli2arb_wdata),
        .cli2arb_wbe    (cli2arb_wbe),
        .cli2arb_stall  (cli2arb_stall),
        .cli2arb_rdata  (cli2arb_rdata),
        .cli2arb_rvalid (cli2arb_rvalid),
        .csr_wr         (csr_wr),
        .csr_idx        (csr_idx),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Client c always presents addr=c, a distinct wdata word and wbe=c+1.
    task automatic set_clients(input logic [CLIENTS-1:0] mask, input logic [2:0] op);
        for (int c = 0; c < CLIENTS; c++) begin
            cli2arb_opcode[c*3 +: 3]    = op;
            cli2arb_addr[c*27 +: 27]    = 27'(c);
            cli2arb_wdata[c*256 +: 256] = {8{32'(32'hA0 + c)}};
            cli2arb_wbe[c*32 +: 32]     = 32'(c + 1);
        end
        cli2arb_valid = mask;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_grant(input string tag, input int client);
        check(tag, {arb2ltc_valid, arb2ltc_addr}, {1'b1, 27'(client)});
    endtask

    int exp_t1 [8]  = '{0, 0, 1, 1, 2, 2, 3, 3};
    int exp_t2 [10] = '{0, 0, 1, 1, 2, 2, 2, 2, 3, 3};
    int exp_t5 [4]  = '{0, 1, 1, 2};

    initial begin
        // Reset state
        set_clients('0, LTC_OP_WRITE);
        repeat (2) @(negedge clk);
        check("rst_valid", arb2ltc_valid, 1'b0);
        check("rst_payload", {arb2ltc_opcode, arb2ltc_addr, arb2ltc_wbe}, '0);
        check("rst_wdata", arb2ltc_wdata, '0);
        check("rst_rvalid", cli2arb_rvalid, '0);
        check("rst_cli_rdata", cli2arb_rdata, '0);
        check("rst_csr", csr_rdata, 4'b0001);

        // Continuous writes, default credits=1: two grants per client
        set_clients(4'b1111, LTC_OP_WRITE);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_grant($sformatf("t1_grant%0d", i), exp_t1[i]);
        end
        check("t1_wbe", arb2ltc_wbe, 32'd4);

        // Client 2 credits=3 -> four grants on its turn
        do_reset();
        set_clients('0, LTC_OP_WRITE);
        csr_idx = 2'd2;
        check("t2_csr_before", csr_rdata, 4'b0001);
        csr_wr = 1'b1;
        csr_wdata = 4'b0011;
        tick();
        csr_wr = 1'b0;
        check("t2_csr_after", csr_rdata, 4'b0011);
        set_clients(4'b1111, LTC_OP_WRITE);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_grant($sformatf("t2_grant%0d", i), exp_t2[i]);
        end

        // Priority mode with clients 1 and 3 requesting
        do_reset();
        set_clients('0, LTC_OP_WRITE);
        csr_idx = 2'd0;
        csr_wr = 1'b1;
        csr_wdata = 4'b1001;
        tick();
        csr_wr = 1'b0;
        check("t3_csr", csr_rdata, 4'b1001);
        set_clients(4'b1010, LTC_OP_WRITE);
        tick();
        check("t3_idle", arb2ltc_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_grant($sformatf("t3_grant%0d", i), 1);
            check($sformatf("t3_stall%0d", i), cli2arb_stall, 4'b1000);
        end

        // Read-tag queue full: 9th read waits for one return
        do_reset();
        set_clients(4'b0001, LTC_OP_READ);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_grant($sformatf("t4_read%0d", i), 0);
        end
        check("t4_opcode", arb2ltc_opcode, LTC_OP_READ);
        check("t4_full_stall", cli2arb_stall, 4'b0001);
        tick();
        check("t4_blocked", arb2ltc_valid, 1'b0);
        arb2ltc_rvalid = 1'b1;
        arb2ltc_rdata = {8{32'hDEAD_BEEF}};
        tick();
        arb2ltc_rvalid = 1'b0;
        check("t4_pop_cycle", arb2ltc_valid, 1'b0);
        check("t4_rvalid", cli2arb_rvalid, 4'b0001);
        check("t4_rdata", cli2arb_rdata, {8{32'hDEAD_BEEF}});
        tick();
        check_grant("t4_ninth", 0);
        check("t4_rvalid_off", cli2arb_rvalid, 4'b0000);

        // Stall held 5 cycles
        do_reset();
        set_clients(4'b1111, LTC_OP_WRITE);
        tick();
        check_grant("t5_first", 0);
        arb2ltc_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_grant($sformatf("t5_hold%0d", i), 0);
            check($sformatf("t5_hold_wbe%0d", i), arb2ltc_wbe, 32'd1);
            check($sformatf("t5_cli_stall%0d", i), cli2arb_stall, 4'b1111);
        end
        arb2ltc_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_grant($sformatf("t5_after%0d", i), exp_t5[i]);
        end

        // Reset with 3 reads outstanding
        do_reset();
        set_clients(4'b0001, LTC_OP_READ);
        repeat (3) tick();
        check_grant("t6_third_read", 0);
        set_clients('0, LTC_OP_READ);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", arb2ltc_valid, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t6_no_rvalid%0d", i), cli2arb_rvalid, 4'b0000);
        end
        set_clients(4'b0100, LTC_OP_READTHROUGH);
        tick();
        check("t6_advance", arb2ltc_valid, 1'b0);
        tick();
        check_grant("t6_new_read", 2);
        set_clients('0, LTC_OP_READ);
        arb2ltc_rvalid = 1'b1;
        arb2ltc_rdata = {8{32'h1234_5678}};
        tick();
        arb2ltc_rvalid = 1'b0;
        check("t6_tag", cli2arb_rvalid, 4'b0100);
        check("t6_rdata", cli2arb_rdata, {8{32'h1234_5678}});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
